// File: rtl/pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer : plays a duty table into the register file, SPI wins.
// Optional SEQ_LOOP_EN repeats the table until stop.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_duty_sequencer #(
  parameter int                DEPTH     = 8,
  parameter int                STEP_W    = 16,
  parameter int                ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] DUTY_ADDR = 7'h04,
  localparam int               IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] interval,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_addr,
  input  logic [7:0]        tbl_wdata,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [7:0]        spi_wdata,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              busy,
  output logic [IDX_W-1:0]  idx,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic [7:0]        tbl_q [DEPTH];
  logic [7:0]        tbl_d [DEPTH];
  logic              seq_issue;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    seq_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        // An SPI request owns the write port this cycle; hold the entry.
        if (!spi_we) begin
          seq_issue = 1'b1;
          cnt_d     = interval;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - STEP_W'(1);
        end else if (idx_q != last_idx) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end else begin
`ifdef SEQ_LOOP_EN
          idx_d   = '0;
          state_d = S_ISSUE;
`else
          idx_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    if (stop) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      done_d    = 1'b0;
      seq_issue = 1'b0;
    end
  end

  always_comb begin
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    if (spi_we) begin
      reg_we_d    = 1'b1;
      reg_addr_d  = spi_addr;
      reg_wdata_d = spi_wdata;
    end else if (seq_issue) begin
      reg_we_d    = 1'b1;
      reg_addr_d  = DUTY_ADDR;
      reg_wdata_d = tbl_q[idx_q];
    end
  end

  // Table update lands after the read above, so a same-cycle write issues the old value.
  always_comb begin
    tbl_d = tbl_q;
    if (tbl_we) begin
      tbl_d[tbl_addr] = tbl_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tbl_q       <= tbl_d;
    end
  end

  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign idx       = idx_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
// Randomized bench for pwm_duty_sequencer against a timeline-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_duty_sequencer;

  localparam int         DEPTH  = 8;
  localparam int         STEP_W = 16;
  localparam int         ADDR_W = 7;
  localparam int         IDX_W  = 3;
  localparam logic [6:0] DUTY   = 7'h04;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop;
  logic [STEP_W-1:0] interval;
  logic [IDX_W-1:0]  last_idx;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_addr;
  logic [7:0]        tbl_wdata;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [7:0]        spi_wdata;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              busy;
  logic [IDX_W-1:0]  idx;
  logic              done;

  always #5 clk = ~clk;

  pwm_duty_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .interval(interval),
    .last_idx(last_idx), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .busy(busy), .idx(idx), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: a sequence is a list of entries, each written at its due cycle
  // (or later if SPI holds the port), the next entry due interval+2 cycles after a write.
  logic [7:0] m_tbl [DEPTH];
  bit         m_active, m_issued;
  int         m_k;
  longint     t, m_due;
  logic       exp_we, exp_busy, exp_done;
  logic [6:0] exp_addr;
  logic [7:0] exp_data;
  int         exp_idx;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 8'h00;
    m_active = 0; m_issued = 0; m_k = 0; m_due = 0;
    exp_we = 0; exp_addr = 0; exp_data = 0; exp_busy = 0; exp_done = 0; exp_idx = 0;
  endtask

  task automatic model_step();
    bit         seq_wr;
    logic [7:0] seq_data;
    seq_wr   = 0;
    seq_data = 8'h00;
    exp_done = 0;
    if (stop) begin
      m_active = 0; m_k = 0;
    end else if (!m_active) begin
      if (start) begin m_active = 1; m_k = 0; m_issued = 0; end
    end else if (!m_issued) begin
      if (!spi_we) begin
        seq_wr = 1; seq_data = m_tbl[m_k]; m_issued = 1;
        m_due = t + longint'(interval) + 2;
      end
    end else if (t + 1 == m_due) begin
      if (m_k == int'(last_idx)) begin
`ifdef SEQ_LOOP_EN
        m_k = 0; m_issued = 0;
`else
        m_active = 0; m_k = 0; exp_done = 1;
`endif
      end else begin
        m_k = (m_k + 1) % DEPTH; m_issued = 0;
      end
    end
    if (spi_we) begin
      exp_we = 1; exp_addr = spi_addr; exp_data = spi_wdata;
    end else if (seq_wr) begin
      exp_we = 1; exp_addr = DUTY; exp_data = seq_data;
    end else begin
      exp_we = 0;
    end
    if (tbl_we) m_tbl[tbl_addr] = tbl_wdata;
    exp_busy = m_active;
    exp_idx  = m_k;
    t++;
  endtask

  task automatic compare_all(input string pfx);
    check_eq({pfx, ".reg_we"},    32'(reg_we),    32'(exp_we));
    check_eq({pfx, ".reg_addr"},  32'(reg_addr),  32'(exp_addr));
    check_eq({pfx, ".reg_wdata"}, 32'(reg_wdata), 32'(exp_data));
    check_eq({pfx, ".busy"},      32'(busy),      32'(exp_busy));
    check_eq({pfx, ".idx"},       32'(idx),       32'(exp_idx));
    check_eq({pfx, ".done"},      32'(done),      32'(exp_done));
  endtask

  task automatic quiet_inputs();
    start = 0; stop = 0; tbl_we = 0; tbl_addr = 0; tbl_wdata = 0;
    spi_we = 0; spi_addr = 0; spi_wdata = 0;
  endtask

  bit did_mid_rst;

  initial begin
    quiet_inputs();
    interval = 16'd2; last_idx = 3'd3;
    t = 0; did_mid_rst = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      compare_all("run");
      if (!did_mid_rst && cyc > 2000 && m_active && m_issued) begin
        did_mid_rst = 1;
        quiet_inputs();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        t++;
      end else begin
        start     = ($urandom_range(0, 7) == 0);
        stop      = ($urandom_range(0, 59) == 0);
        spi_we    = ($urandom_range(0, 5) == 0);
        spi_addr  = 7'($urandom);
        spi_wdata = 8'($urandom);
        tbl_we    = ($urandom_range(0, 3) == 0);
        tbl_addr  = 3'($urandom);
        tbl_wdata = 8'($urandom);
        if ($urandom_range(0, 31) == 0) interval = 16'($urandom_range(0, 6));
        if ($urandom_range(0, 31) == 0) last_idx = 3'($urandom);
        model_step();
      end
    end
    @(negedge clk);
    compare_all("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
